// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared state encoding and default width for the bit-serial subtractor.
// Rev 1.0
`default_nettype none

package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit difference and borrow cell, purely combinational.
// Rev 1.0
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// serial_subtractor: computes a - b one bit per clock, LSB first, on a start/done handshake.
// Rev 1.0
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               amsb_q, amsb_d;
  logic               bmsb_q, bmsb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  logic               fs_d;
  logic               fs_bout;
  logic               last_bit;

  full_subtractor u_fs (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          sa_d     = a;
          sb_d     = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          amsb_d   = a[WIDTH-1];
          bmsb_d   = b[WIDTH-1];
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        sa_d     = sa_q >> 1;
        sb_d     = sb_q >> 1;
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        // The final bit is the result MSB, so the visible outputs load from the live cell output.
        if (last_bit) begin
          state_d = DONE;
          diff_d  = {fs_d, res_q[WIDTH-1:1]};
          bout_d  = fs_bout;
          ovf_d   = (amsb_q ^ bmsb_q) & (fs_d ^ amsb_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the bit-serial subtractor.
// Rev 1.0
`default_nettype none

module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  int n_checks;
  int n_errors;
  int done_cnt;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    tick();
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
  endtask

  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
  endtask

  task automatic expect_result(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    logic [8:0] full;
    logic       e_ovf;
    full  = {1'b0, ea} - {1'b0, eb};
    e_ovf = (ea[7] != eb[7]) && (full[7] != ea[7]);
    check(tag, {22'd0, ovf, bout, diff}, {22'd0, e_ovf, full[8], full[7:0]});
  endtask

  initial begin
    int cyc, bcyc, snap, accepts;
    logic stable;
    logic [7:0] ra, rb;

    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", {27'd0, busy, done, bout, ovf, |diff}, 32'd0);

    // Basic: 0x5A - 0x3C
    start_op(8'h5A, 8'h3C);
    wait_done(cyc, bcyc);
    check("basic_latency", cyc, 8);
    check("basic_busy_cycles", bcyc, 8);
    check("basic_diff", {24'd0, diff}, 32'h1E);
    check("basic_flags", {30'd0, bout, ovf}, 32'd0);
    tick();
    check("basic_back_idle", {30'd0, busy, done}, 32'd0);

    // Underflow and signed overflow
    start_op(8'h00, 8'h01);
    wait_done(cyc, bcyc);
    check("uflow_result", {22'd0, ovf, bout, diff}, {22'd0, 1'b0, 1'b1, 8'hFF});
    tick();
    start_op(8'h80, 8'h01);
    wait_done(cyc, bcyc);
    check("sovf_result", {22'd0, ovf, bout, diff}, {22'd0, 1'b1, 1'b0, 8'h7F});
    tick();

    // Start during RUN is ignored
    snap = done_cnt;
    start_op(8'h10, 8'h01);
    tick();
    tick();
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("ignore_latency", cyc, 5);
    check("ignore_diff", {24'd0, diff}, 32'h0F);
    repeat (12) tick();
    check("ignore_one_done", done_cnt - snap, 1);
    check("ignore_idle", {31'd0, busy}, 32'd0);

    // Back-to-back via start held during DONE
    start_op(8'h22, 8'h11);
    wait_done(cyc, bcyc);
    check("b2b_first", {24'd0, diff}, 32'h11);
    start_op(8'h03, 8'h05);
    stable = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (diff !== 8'h11) stable = 1'b0;
      tick();
      cyc++;
    end
    check("b2b_stable", {31'd0, stable}, 32'd1);
    check("b2b_spacing", cyc + 1, 9);
    check("b2b_second", {22'd0, ovf, bout, diff}, {22'd0, 1'b0, 1'b1, 8'hFE});
    tick();

    // Asynchronous reset mid-operation
    start_op(8'h5A, 8'h3C);
    repeat (3) tick();
    snap = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_outputs", {23'd0, busy, done, bout, ovf, diff}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (12) tick();
    check("abort_no_done", done_cnt - snap, 0);
    start_op(8'h7F, 8'h80);
    wait_done(cyc, bcyc);
    check("post_reset_result", {22'd0, ovf, bout, diff}, {22'd0, 1'b1, 1'b1, 8'hFF});
    tick();

    // Boundary cases
    start_op(8'hA5, 8'hA5);
    wait_done(cyc, bcyc);
    check("equal_operands", {22'd0, ovf, bout, diff}, 32'd0);
    tick();
    start_op(8'hC3, 8'h00);
    wait_done(cyc, bcyc);
    check("b_zero", {22'd0, ovf, bout, diff}, {22'd0, 1'b0, 1'b0, 8'hC3});
    tick();
    start_op(8'h00, 8'hFF);
    wait_done(cyc, bcyc);
    check("a0_bones", {22'd0, ovf, bout, diff}, {22'd0, 1'b0, 1'b1, 8'h01});
    tick();

    // Random sweep against a golden model
    snap    = done_cnt;
    accepts = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      start_op(ra, rb);
      accepts++;
      wait_done(cyc, bcyc);
      if (cyc != 8) check("rand_latency", cyc, 8);
      expect_result("rand_result", ra, rb);
      tick();
    end
    check("rand_done_count", done_cnt - snap, accepts);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
